mem_req_adapter: RTL and testbench



---
 rtl/mem_req_adapter.sv | 144 ++++++++++++++
 tb/tb_mem_req_adapter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_adapter.sv
// Request/response front-end for a single-port synchronous RAM: clears the RAM after
// reset, issues reads and writes, and buffers the registered read data for the consumer.
module mem_req_adapter #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter int                RSP_DEPTH = 3,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              init_done_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1) + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              inflight;
  logic              inflight_nxt;
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  occ_nxt;
  logic              ready_r;
  logic              ready_nxt;
  logic              done_r;
  logic              accept;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // ready_r is only ever high in RUN, so it alone qualifies an accept
  assign accept      = ready_r & req_valid_i;
  assign push        = inflight;
  assign pop         = (fifo_cnt != '0) & rsp_ready_i;
  assign req_ready_o = ready_r;
  assign init_done_o = done_r;
  assign rsp_valid_o = (fifo_cnt != '0);
  assign rsp_rdata_o = fifo_mem[rd_ptr];

  // Next-state, RAM port drive and next occupancy
  always_comb begin
    state_nxt    = state;
    inflight_nxt = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = req_addr_i;
    mem_wdata_o  = req_wdata_i;
    case (state)
      ST_INIT: begin
        mem_we_o    = rst_ni;
        mem_addr_o  = init_cnt;
        mem_wdata_o = INIT_VAL;
        if (init_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_INIT;
        end
      end
      ST_RUN: begin
        mem_we_o     = rst_ni & accept & req_we_i;
        inflight_nxt = accept & ~req_we_i;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
    cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    // Ready counts the read whose data lands in the FIFO next cycle as occupied
    occ_nxt   = cnt_nxt + CNT_W'(inflight_nxt);
    ready_nxt = (state_nxt == ST_RUN) && (occ_nxt < CNT_W'(RSP_DEPTH));
  end

  // Control state, counters and FIFO pointers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      ready_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      fifo_cnt <= cnt_nxt;
      ready_r  <= ready_nxt;
      done_r   <= (state_nxt == ST_RUN);
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + ADDR_W'(1);
      end else begin
        init_cnt <= init_cnt;
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end else begin
        rd_ptr <= rd_ptr;
      end
    end
  end

  // Response storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      fifo_mem[wr_ptr] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_req_adapter.sv
// Bench for mem_req_adapter: RAM model, transaction-level scoreboard, vector table,
// directed corner sequences and a randomized phase.
module tb_mem_req_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_req_adapter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .init_done_o (init_done),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Single-port RAM with registered read (old data on a write cycle)
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [31:0] d;
    int          c;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [64];
  rsp_t        rsp_q [$];
  logic [31:0] tbl_q [$];
  int          init_left;
  int          cyc;
  int          acc_total;
  logic        last_acc;
  vec_t        tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model at negedge, then advance the model.
  task automatic cycle();
    logic acc;
    rsp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (init_left > 0) begin
      check("init_we", {31'd0, mem_we}, {31'd0, rst_n});
      if (rst_n) begin
        check("init_addr", {26'd0, mem_addr}, 32'(64 - init_left));
        check("init_wdata", mem_wdata, 32'h0);
      end
      check("init_done_low", {31'd0, init_done}, 32'd0);
      check("init_ready_low", {31'd0, req_ready}, 32'd0);
      check("stale_rsp", {31'd0, rsp_valid}, 32'd0);
    end else begin
      check("done", {31'd0, init_done}, 32'd1);
      check("ready", {31'd0, req_ready}, {31'd0, rsp_q.size() < 3});
      check("rsp_valid", {31'd0, rsp_valid},
            {31'd0, (rsp_q.size() > 0) && (rsp_q[0].c <= cyc - 2)});
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.d);
          if (tbl_q.size() > 0) check("tbl_rdata", rsp_rdata, tbl_q.pop_front());
        end
      end
      acc = req_valid && req_ready;
      check("mem_we", {31'd0, mem_we}, {31'd0, rst_n && acc && req_we});
      if (acc) begin
        check("mem_addr", {26'd0, mem_addr}, {26'd0, req_addr});
        if (req_we) begin
          check("mem_wdata", mem_wdata, req_wdata);
          ref_mem[req_addr] = req_wdata;
        end else begin
          e.d = ref_mem[req_addr];
          e.c = cyc;
          rsp_q.push_back(e);
        end
        acc_total++;
      end
    end
    last_acc = acc;
    if (!rst_n) begin
      rsp_q.delete();
      tbl_q.delete();
      init_left = 64;
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    end else if (init_left > 0) begin
      init_left--;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic we, input logic [5:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      cycle();
      n++;
    end
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles (addr %0d)", a);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 64; i++) ram[i] = 32'hA5A5_0000 | 32'(i);
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 6'd0;
    req_wdata = 32'h0; rsp_ready = 1'b1;
    init_left = 64; cyc = 0; acc_total = 0; last_acc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cycle();
    rst_n = 1'b1;
    repeat (64) cycle();

    // Vector table: read-after-write, unwritten address, overwrite
    tbl[0] = '{1'b1, 6'd5,  32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 6'd5,  32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 6'd9,  32'h0,         32'h0000_0000};
    tbl[3] = '{1'b1, 6'd9,  32'h1234_5678, 32'h0};
    tbl[4] = '{1'b0, 6'd9,  32'h0,         32'h1234_5678};
    tbl[5] = '{1'b0, 6'd63, 32'h0,         32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (!tbl[i].we) tbl_q.push_back(tbl[i].exp);
    end
    repeat (5) cycle();
    check("tbl_drained", 32'(tbl_q.size()), 32'd0);

    // Back-to-back reads at full throughput
    for (int a = 0; a < 16; a++) send(1'b1, 6'(a), 32'h1000_0000 + 32'(a * 7));
    c0 = cyc;
    for (int a = 0; a < 16; a++) send(1'b0, 6'(a), 32'h0);
    check("b2b_cycles", 32'(cyc - c0), 32'd16);
    repeat (5) cycle();

    // Backpressure: three accepts then stall, then resume
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd3;
    c0 = acc_total;
    repeat (6) cycle();
    check("bp_accepts", 32'(acc_total - c0), 32'd3);
    check("bp_ready_low", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    repeat (8) cycle();
    req_valid = 1'b0;
    repeat (6) cycle();

    // Reset with two buffered responses and one in flight
    send(1'b1, 6'd20, 32'hCAFE_F00D);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd20;
    repeat (3) cycle();
    check("pre_rst_outstanding", 32'(rsp_q.size()), 32'd3);
    req_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (64) cycle();
    send(1'b0, 6'd20, 32'h0);
    tbl_q.push_back(32'h0);
    send(1'b0, 6'd5, 32'h0);
    tbl_q.push_back(32'h0);
    repeat (5) cycle();
    check("post_rst_drained", 32'(tbl_q.size()), 32'd0);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 2) == 0);
      req_addr  = 6'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) cycle();
    check("final_empty", 32'(rsp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
